sobel_row_sequencer: RTL and testbench

SOBEL_ROW_SEQUENCER -- requirements
Module: sobel_row_sequencer

---
 rtl/sobel_row_sequencer_pkg.sv | 21 ++
 rtl/sobel_row_sequencer_addr_gen.sv | 18 +
 rtl/sobel_row_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_sobel_row_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_row_sequencer_pkg.sv
// rtl/sobel_row_sequencer_pkg.sv - shared accelerator count, widths and state encoding
// NUM_SOBEL_ACCELERATORS may be overridden on the command line; defaults to 4.
`ifndef NUM_SOBEL_ACCELERATORS
`define NUM_SOBEL_ACCELERATORS 4
`endif

package sobel_row_sequencer_pkg;
  localparam int unsigned N_ACC   = `NUM_SOBEL_ACCELERATORS;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned CHUNK_W = N_ACC + 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_PRIME = 3'd2,
    S_LOAD  = 3'd3,
    S_WRITE = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;
endpackage

// File: rtl/sobel_row_sequencer_addr_gen.sv
// rtl/sobel_row_sequencer_addr_gen.sv - sobel_addr_gen: base + (row+row_off)*n_cols + col + col_off
// All arithmetic wraps at 32 bits; no saturation.
module sobel_addr_gen
  import sobel_row_sequencer_pkg::*;
(
  input  logic [ADDR_W-1:0] i_base,
  input  logic [15:0]       i_row,
  input  logic [15:0]       i_n_cols,
  input  logic [15:0]       i_col,
  input  logic [1:0]        i_row_off,
  input  logic              i_col_off,
  output logic [ADDR_W-1:0] o_addr
);
  logic [ADDR_W-1:0] w_row;

  assign w_row  = ADDR_W'(i_row) + ADDR_W'(i_row_off);
  assign o_addr = i_base + w_row * ADDR_W'(i_n_cols) + ADDR_W'(i_col) + ADDR_W'(i_col_off);
endmodule

// File: rtl/sobel_row_sequencer.sv
// rtl/sobel_row_sequencer.sv - strip/row walker feeding N Sobel accelerators over an image
// SOBEL_SEQ_PERF_CNT_EN adds perf_cycles/perf_stalls counters and ports.
module sobel_row_sequencer
  import sobel_row_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic [15:0]       cfg_n_rows,
  input  logic [15:0]       cfg_n_cols,
  input  logic [ADDR_W-1:0] cfg_src_base,
  input  logic [ADDR_W-1:0] cfg_dst_base,
  output logic              srd_req,
  output logic [ADDR_W-1:0] srd_addr,
  input  logic              srd_ack,
  output logic              srow_shift,
  output logic              swt_req,
  output logic [ADDR_W-1:0] swt_addr,
  input  logic              swt_ack,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef SOBEL_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
`endif
);
  state_t            r_state, w_state_nxt;
  logic [15:0]       r_n_rows, r_n_cols, r_row, r_col;
  logic [15:0]       w_row_nxt, w_col_nxt;
  logic [ADDR_W-1:0] r_src, r_dst;
  logic              r_prime_cnt, w_prime_nxt;
  logic              r_cfg_err, w_err_nxt;
  logic              w_latch;
  logic [1:0]        w_rd_row_off;
  logic [16:0]       w_row_p3, w_col_end, w_col_step;
  logic [ADDR_W-1:0] w_rd_addr, w_wt_addr;

  assign w_row_p3   = {1'b0, r_row} + 17'd3;
  assign w_col_end  = {1'b0, r_col} + 17'(CHUNK_W);
  assign w_col_step = {1'b0, r_col} + 17'(N_ACC);

  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    w_prime_nxt  = r_prime_cnt;
    w_err_nxt    = r_cfg_err;
    w_latch      = 1'b0;
    w_rd_row_off = 2'd0;
    srd_req      = 1'b0;
    swt_req      = 1'b0;
    done         = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (go) begin
        w_latch     = 1'b1;
        w_err_nxt   = 1'b0;
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (r_n_rows < 16'd3 || {1'b0, r_n_cols} < 17'(CHUNK_W)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_prime_nxt = 1'b0;
          w_state_nxt = S_PRIME;
        end
      end
      S_PRIME: begin
        srd_req      = 1'b1;
        w_rd_row_off = {1'b0, r_prime_cnt};
        if (srd_ack) begin
          w_prime_nxt = 1'b1;
          if (r_prime_cnt) w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        srd_req      = 1'b1;
        w_rd_row_off = 2'd2;
        if (srd_ack) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        swt_req = 1'b1;
        if (swt_ack) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (w_row_p3 < {1'b0, r_n_rows}) begin
          w_row_nxt   = r_row + 16'd1;
          w_state_nxt = S_LOAD;
        end else if (w_col_end < {1'b0, r_n_cols}) begin
          // Final strip is pulled left so it ends exactly on the last column.
          if (w_col_step + 17'(CHUNK_W) > {1'b0, r_n_cols})
            w_col_nxt = r_n_cols - 16'(CHUNK_W);
          else
            w_col_nxt = w_col_step[15:0];
          w_row_nxt   = '0;
          w_prime_nxt = 1'b0;
          w_state_nxt = S_PRIME;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_n_rows    <= '0;
      r_n_cols    <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_prime_cnt <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_prime_cnt <= w_prime_nxt;
      r_cfg_err   <= w_err_nxt;
      if (w_latch) begin
        r_n_rows <= cfg_n_rows;
        r_n_cols <= cfg_n_cols;
        r_src    <= cfg_src_base;
        r_dst    <= cfg_dst_base;
      end
    end
  end

  sobel_addr_gen u_rd_addr (
    .i_base    (r_src),
    .i_row     (r_row),
    .i_n_cols  (r_n_cols),
    .i_col     (r_col),
    .i_row_off (w_rd_row_off),
    .i_col_off (1'b0),
    .o_addr    (w_rd_addr)
  );

  sobel_addr_gen u_wt_addr (
    .i_base    (r_dst),
    .i_row     (r_row),
    .i_n_cols  (r_n_cols),
    .i_col     (r_col),
    .i_row_off (2'd1),
    .i_col_off (1'b1),
    .o_addr    (w_wt_addr)
  );

  assign srd_addr   = srd_req ? w_rd_addr : '0;
  assign swt_addr   = swt_req ? w_wt_addr : '0;
  assign srow_shift = srd_req & srd_ack;
  assign cfg_err    = r_cfg_err;

`ifdef SOBEL_SEQ_PERF_CNT_EN
  logic [31:0] r_perf_cycles, r_perf_stalls;
  logic        w_stall;

  assign w_stall = (srd_req & ~srd_ack) | (swt_req & ~swt_ack);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else if (w_latch) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (busy && r_perf_cycles != '1)    r_perf_cycles <= r_perf_cycles + 32'd1;
      if (w_stall && r_perf_stalls != '1) r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_stalls = r_perf_stalls;
`endif
endmodule

// File: tb/tb_sobel_row_sequencer.sv
// tb/tb_sobel_row_sequencer.sv - directed self-checking bench for sobel_row_sequencer
// Memory-side responder with programmable ack delay; expected addresses computed by hand.
module tb_sobel_row_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0;
  logic [15:0] cfg_n_rows = '0, cfg_n_cols = '0;
  logic [31:0] cfg_src_base = '0, cfg_dst_base = '0;
  logic        srd_req, srow_shift, swt_req, busy, done, cfg_err;
  logic        srd_ack = 1'b0, swt_ack = 1'b0;
  logic [31:0] srd_addr, swt_addr;
`ifdef SOBEL_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  int n_vec = 0, n_err = 0;
  int rd_delay = 0, wr_delay = 0;
  int rd_wait, wr_wait, rd_tgt, wr_tgt;
  logic rd_pend = 1'b0, wr_pend = 1'b0;
  logic [31:0] rd_hold, wr_hold;
  int busy_cnt = 0, done_cnt = 0, shift_cnt = 0, req_cycles = 0;
  int excl_viol = 0, stab_viol = 0;
  int n_wait;
  logic [31:0] rd_q[$], wr_q[$], exp_rd[$], exp_wr[$];

  always #5 clk = ~clk;

  sobel_row_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .go           (go),
    .cfg_n_rows   (cfg_n_rows),
    .cfg_n_cols   (cfg_n_cols),
    .cfg_src_base (cfg_src_base),
    .cfg_dst_base (cfg_dst_base),
    .srd_req      (srd_req),
    .srd_addr     (srd_addr),
    .srd_ack      (srd_ack),
    .srow_shift   (srow_shift),
    .swt_req      (swt_req),
    .swt_addr     (swt_addr),
    .swt_ack      (swt_ack),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
`ifdef SOBEL_SEQ_PERF_CNT_EN
    ,
    .perf_cycles  (perf_cycles),
    .perf_stalls  (perf_stalls)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder: acks after a per-request delay (negative delay = random 0..5).
  always @(negedge clk) begin
    if (!reset_n) begin
      srd_ack = 1'b0;
      swt_ack = 1'b0;
      rd_pend = 1'b0;
      wr_pend = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (srd_req || swt_req) req_cycles++;
      if (srd_req && swt_req) excl_viol++;
      srd_ack = 1'b0;
      swt_ack = 1'b0;
      if (srd_req) begin
        if (!rd_pend) begin
          rd_pend = 1'b1;
          rd_hold = srd_addr;
          rd_wait = 0;
          rd_tgt  = (rd_delay < 0) ? int'($urandom_range(5, 0)) : rd_delay;
        end else if (srd_addr != rd_hold) stab_viol++;
        if (rd_wait >= rd_tgt) begin
          srd_ack = 1'b1;
          rd_q.push_back(srd_addr);
          rd_pend = 1'b0;
        end else rd_wait++;
      end else if (rd_pend) begin
        stab_viol++;
        rd_pend = 1'b0;
      end
      if (swt_req) begin
        if (!wr_pend) begin
          wr_pend = 1'b1;
          wr_hold = swt_addr;
          wr_wait = 0;
          wr_tgt  = (wr_delay < 0) ? int'($urandom_range(5, 0)) : wr_delay;
        end else if (swt_addr != wr_hold) stab_viol++;
        if (wr_wait >= wr_tgt) begin
          swt_ack = 1'b1;
          wr_q.push_back(swt_addr);
          wr_pend = 1'b0;
        end else wr_wait++;
      end else if (wr_pend) begin
        stab_viol++;
        wr_pend = 1'b0;
      end
    end
  end

  always begin
    @(negedge clk);
    #4;
    if (reset_n && srow_shift) shift_cnt++;
  end

  task automatic run_img(input logic [15:0] rows, input logic [15:0] cols,
                         input logic [31:0] src, input logic [31:0] dst, input int inj);
    int n;
    rd_q.delete();
    wr_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    shift_cnt = 0;
    @(negedge clk);
    cfg_n_rows = rows;
    cfg_n_cols = cols;
    cfg_src_base = src;
    cfg_dst_base = dst;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
      if (n == inj) begin
        cfg_n_rows = 16'd9;
        cfg_n_cols = 16'd40;
        go = 1'b1;
      end else go = 1'b0;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("done_once", done_cnt, 32'd1);
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, "_rd_n"}, rd_q.size(), exp_rd.size());
    chk({tag, "_wr_n"}, wr_q.size(), exp_wr.size());
    chk({tag, "_shift_n"}, shift_cnt, exp_rd.size());
    for (int i = 0; i < exp_rd.size(); i++)
      if (i < rd_q.size()) chk($sformatf("%s_rd%0d", tag, i), rd_q[i], exp_rd[i]);
    for (int i = 0; i < exp_wr.size(); i++)
      if (i < wr_q.size()) chk($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_wr[i]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outs", {26'd0, srd_req, swt_req, srow_shift, busy, done, cfg_err}, 32'd0);
    chk("rst_srd_addr", srd_addr, 32'd0);
    chk("rst_swt_addr", swt_addr, 32'd0);
    reset_n = 1'b1;

    exp_rd = '{32'h0, 32'h6, 32'hC};
    exp_wr = '{32'h1007};
    run_img(16'd3, 16'd6, 32'h0, 32'h1000, 0);
    cmp_all("img3x6");
    chk("img3x6_busy_cyc", busy_cnt, 32'd7);
    chk("img3x6_err", {31'd0, cfg_err}, 32'd0);

    exp_rd = '{32'h0, 32'h8, 32'h10, 32'h18, 32'h20, 32'h2, 32'hA, 32'h12, 32'h1A, 32'h22};
    exp_wr = '{32'h1009, 32'h1011, 32'h1019, 32'h100B, 32'h1013, 32'h101B};
    run_img(16'd5, 16'd8, 32'h0, 32'h1000, 0);
    cmp_all("img5x8");
    chk("img5x8_busy_cyc", busy_cnt, 32'd24);

    exp_rd.delete();
    exp_wr.delete();
    run_img(16'd2, 16'd8, 32'h0, 32'h1000, 0);
    cmp_all("bad_rows");
    chk("bad_rows_err", {31'd0, cfg_err}, 32'd1);
    chk("bad_rows_busy_cyc", busy_cnt, 32'd2);
    run_img(16'd5, 16'd5, 32'h0, 32'h1000, 0);
    cmp_all("bad_cols");
    chk("bad_cols_err", {31'd0, cfg_err}, 32'd1);

    exp_rd = '{32'h100, 32'h106, 32'h10C};
    exp_wr = '{32'h2007};
    run_img(16'd3, 16'd6, 32'h100, 32'h2000, 0);
    cmp_all("err_clear");
    chk("err_cleared", {31'd0, cfg_err}, 32'd0);

    rd_delay = -1;
    wr_delay = -1;
    exp_rd = '{32'h0, 32'h8, 32'h10, 32'h18, 32'h20, 32'h2, 32'hA, 32'h12, 32'h1A, 32'h22};
    exp_wr = '{32'h1009, 32'h1011, 32'h1019, 32'h100B, 32'h1013, 32'h101B};
    run_img(16'd5, 16'd8, 32'h0, 32'h1000, 0);
    cmp_all("rand");
    rd_delay = 0;
    wr_delay = 0;

    exp_rd = '{32'h0, 32'h6, 32'hC};
    exp_wr = '{32'h1007};
    run_img(16'd3, 16'd6, 32'h0, 32'h1000, 3);
    cmp_all("go_busy");

    wr_delay = 3;
    @(negedge clk);
    cfg_n_rows = 16'd5;
    cfg_n_cols = 16'd8;
    cfg_src_base = 32'h0;
    cfg_dst_base = 32'h1000;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n_wait = 0;
    while (!swt_req && n_wait < 200) begin
      @(negedge clk);
      n_wait++;
    end
    chk("rst_wr_reached", {31'd0, swt_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_outs", {26'd0, srd_req, swt_req, srow_shift, busy, done, cfg_err}, 32'd0);
    chk("rst_async_swt_addr", swt_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wr_delay = 0;
    req_cycles = 0;
    repeat (20) @(negedge clk);
    chk("rst_no_reissue", req_cycles, 32'd0);
    chk("rst_idle_busy", {31'd0, busy}, 32'd0);
    exp_rd = '{32'h0, 32'h6, 32'hC};
    exp_wr = '{32'h1007};
    run_img(16'd3, 16'd6, 32'h0, 32'h1000, 0);
    cmp_all("post_rst");

`ifdef SOBEL_SEQ_PERF_CNT_EN
    rd_delay = 2;
    run_img(16'd3, 16'd6, 32'h0, 32'h1000, 0);
    cmp_all("perf");
    chk("perf_stalls", perf_stalls, 32'd6);
    chk("perf_cycles", perf_cycles, 32'd13);
    chk("perf_busy_cyc", busy_cnt, 32'd13);
    rd_delay = 0;
`endif

    chk("rd_wr_exclusive", excl_viol, 32'd0);
    chk("req_addr_stable", stab_viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
